// File: rtl/neuron_seq_ctrl_if.sv
// Handshake and ROM bus bundle for the time-multiplexed neuron layer.
// master = layer engine side, slave = surrounding environment.
interface neuron_seq_ctrl_if #(
  parameter int NUM_IN  = 10,
  parameter int NUM_OUT = 10,
  parameter int AW      = 7,
  parameter int OW      = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*NUM_IN-1:0]    in_vec;
  logic                   w_rd;
  logic [AW-1:0]          w_addr;
  logic [OW-1:0]          b_addr;
  logic [7:0]             w_data;
  logic [15:0]            b_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*NUM_OUT-1:0]   out_vec;
  logic                   busy;

  modport master (
    input  in_valid, in_vec, w_data, b_data, out_ready,
    output in_ready, w_rd, w_addr, b_addr, out_valid,
    output out_vec, busy
  );

  modport slave (
    output in_valid, in_vec, w_data, b_data, out_ready,
    input  in_ready, w_rd, w_addr, b_addr, out_valid,
    input  out_vec, busy
  );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Time-multiplexed fully-connected layer: one signed 8x8 MAC walks
// every (output, input) pair, then bias/ReLU/saturate/round per neuron.
module neuron_seq_ctrl #(
  parameter int NUM_IN  = 10,
  parameter int NUM_OUT = 10,
  parameter int AW      = 7,
  parameter int OW      = 4
) (
  input  logic clk,
  input  logic reset,
  neuron_seq_ctrl_if.master bus
);

  localparam int IW  = $clog2(NUM_IN);
  localparam int OIW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MAC, S_TAIL, S_ACT, S_OUT
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]      i_q;
  logic [OW-1:0]      o_q;
  logic [AW-1:0]      addr_q;
  logic               pend_q;
  logic [IW-1:0]      pidx_q;
  logic signed [22:0] acc_q;
  logic signed [7:0]  a_q [NUM_IN];
  logic [7:0]         n_q [NUM_OUT];

  logic               accept;
  logic               issue;
  logic               act;
  logic               last_i;
  logic               last_o;
  logic signed [7:0]  a_sel;
  logic signed [15:0] a16;
  logic signed [15:0] w16;
  logic signed [15:0] prod;
  logic signed [22:0] prod_ext;
  logic signed [22:0] bias_ext;
  logic [8:0]         q9;
  logic [7:0]         quant;

  assign accept = (state == S_IDLE) && bus.in_valid;
  assign issue  = (state == S_MAC);
  assign act    = (state == S_ACT);
  assign last_i = (i_q == IW'(NUM_IN - 1));
  assign last_o = (o_q == OW'(NUM_OUT - 1));

  assign bus.w_addr = addr_q;
  assign bus.b_addr = o_q;

  // Product of the returning weight with its activation, plus bias.
  always_comb begin
    a_sel    = a_q[pidx_q];
    a16      = {{8{a_sel[7]}}, a_sel};
    w16      = {{8{bus.w_data[7]}}, bus.w_data};
    prod     = a16 * w16;
    prod_ext = {{7{prod[15]}}, prod};
    bias_ext = {{7{bus.b_data[15]}}, bus.b_data};
  end

  // ReLU, saturate and round-half-up of the finished accumulator.
  always_comb begin
    q9 = {1'b0, acc_q[13:6]} + {8'b0, acc_q[5]};
    quant = q9[7:0];
    if (acc_q[22])
      quant = 8'd0;
    else if (|acc_q[21:13])
      quant = 8'd127;
    else if (q9 == 9'd128)
      quant = 8'd127;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.w_rd      = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid)
          state_n = S_MAC;
      end
      S_MAC: begin
        bus.w_rd = 1'b1;
        if (last_i)
          state_n = S_TAIL;
      end
      S_TAIL: state_n = S_ACT;
      S_ACT:  state_n = last_o ? S_OUT : S_MAC;
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Counters, activation copy, accumulator and result slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q    <= '0;
      o_q    <= '0;
      addr_q <= '0;
      pend_q <= 1'b0;
      pidx_q <= '0;
      acc_q  <= '0;
      for (int k = 0; k < NUM_IN; k++)
        a_q[k] <= '0;
      for (int k = 0; k < NUM_OUT; k++)
        n_q[k] <= '0;
    end else begin
      pend_q <= issue;
      pidx_q <= i_q;
      if (accept) begin
        for (int k = 0; k < NUM_IN; k++)
          a_q[k] <= bus.in_vec[8*k +: 8];
        i_q    <= '0;
        o_q    <= '0;
        addr_q <= '0;
      end
      if (issue) begin
        i_q    <= i_q + IW'(1);
        addr_q <= addr_q + AW'(1);
      end
      if (pend_q)
        acc_q <= ((pidx_q == '0) ? bias_ext : acc_q) + prod_ext;
      if (act) begin
        n_q[o_q[OIW-1:0]] <= quant;
        i_q <= '0;
        if (!last_o)
          o_q <= o_q + OW'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign bus.out_vec[8*g +: 8] = n_q[g];
  end

endmodule
